bcd_stopwatch_mux: RTL and testbench

Parametrised multi-digit decimal stopwatch with start/stop, lap-hold and clear controls. It drives a time-multiplexed, active-low seven-segment display. It counts BCD digits at a divided tick rate and shows either the live count or a frozen lap snapshot. It replaces the fixed 4-digit free-running counter/display and sits between the board button conditioning and the segment/anode pins.

---
 rtl/bcd_stopwatch_mux_if.sv | 38 +++
 rtl/bcd_stopwatch_mux.sv | 223 ++++++++++++++++++++++
 tb/tb_bcd_stopwatch_mux.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_stopwatch_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_stopwatch_mux_if
// Description : Button inputs and display/status outputs of the decimal
//               stopwatch, bundled so one connection carries the whole block
//               boundary.
//               master : button conditioning side (drives buttons, sees display)
//               slave  : stopwatch core (samples buttons, drives display)
//               Signals:
//                 btn_start_stop, btn_lap, btn_clear : debounced levels
//                 seg [7:0]    : active-low {dp,g,f,e,d,c,b,a}
//                 an  [DIGITS] : active-low one-hot digit enable
//                 running, lap_active, overflow : status flags
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_stopwatch_mux_if #(
    parameter int DIGITS = 4
);
    logic              btn_start_stop;
    logic              btn_lap;
    logic              btn_clear;
    logic [7:0]        seg;
    logic [DIGITS-1:0] an;
    logic              running;
    logic              lap_active;
    logic              overflow;

    modport master (
        output btn_start_stop, btn_lap, btn_clear,
        input  seg, an, running, lap_active, overflow
    );

    modport slave (
        input  btn_start_stop, btn_lap, btn_clear,
        output seg, an, running, lap_active, overflow
    );
endinterface
`default_nettype wire

// File: rtl/bcd_stopwatch_mux.sv
`default_nettype none
// ============================================================================
// Module      : bcd_stopwatch_mux
// Description : Multi-digit BCD stopwatch with start/stop, lap-hold and clear
//               controls, driving a time-multiplexed active-low 7-segment
//               display.
//               Parameters:
//                 DIGITS      : number of BCD digits / anodes (1..8)
//                 TICK_DIV    : mclk cycles per count tick (>= 2)
//                 REFRESH_DIV : mclk cycles per digit scan step (>= 2)
//                 DP_POS      : digit whose decimal point is lit
//                               (DP_POS = DIGITS turns the point off)
//               Ports:
//                 mclk : system clock, rising edge
//                 rst  : synchronous active-high reset
//                 bus  : slave side of bcd_stopwatch_mux_if
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_mux #(
    parameter int DIGITS      = 4,
    parameter int TICK_DIV    = 1000000,
    parameter int REFRESH_DIV = 100000,
    parameter int DP_POS      = 2
) (
    input  logic               mclk,
    input  logic               rst,
    bcd_stopwatch_mux_if.slave bus
);

    localparam int C_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int C_PRE_W = $clog2(TICK_DIV);
    localparam int C_REF_W = $clog2(REFRESH_DIV);
    localparam int C_CNT_W = 4 * DIGITS;

    localparam logic [C_PRE_W-1:0] C_PRE_LAST = C_PRE_W'(TICK_DIV - 1);
    localparam logic [C_REF_W-1:0] C_REF_LAST = C_REF_W'(REFRESH_DIV - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(DIGITS - 1);

    // An out-of-range DP_POS must never alias onto a real digit index.
    localparam bit                 C_DP_EN  = (DP_POS < DIGITS);
    localparam logic [C_IDX_W-1:0] C_DP_IDX = C_DP_EN ? C_IDX_W'(DP_POS) : '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]         btn_prev_q;        // {clear, lap, start_stop}
    logic               running_q,    running_d;
    logic               lap_active_q, lap_active_d;
    logic               overflow_q,   overflow_d;
    logic [C_CNT_W-1:0] digits_q,     digits_d;
    logic [C_CNT_W-1:0] snap_q,       snap_d;
    logic [C_PRE_W-1:0] pre_q,        pre_d;
    logic [C_REF_W-1:0] ref_q,        ref_d;
    logic [C_IDX_W-1:0] idx_q,        idx_d;
    logic [7:0]         seg_q,        seg_d;
    logic [DIGITS-1:0]  an_q,         an_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               ev_ss_w;
    logic               ev_lap_w;
    logic               ev_clr_w;
    logic               clear_w;
    logic               tick_w;
    logic               wrap_w;
    logic               ref_last_w;
    logic [C_CNT_W-1:0] digits_inc_w;
    logic [C_CNT_W-1:0] disp_w;
    logic [3:0]         disp_digit_w;

    // Segment pattern with the decimal point off; dp is merged in later.
    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    // Rising-edge events. prev resets high so a button held through reset
    // does not fire on release of reset.
    assign ev_ss_w  = bus.btn_start_stop & ~btn_prev_q[0];
    assign ev_lap_w = bus.btn_lap        & ~btn_prev_q[1];
    assign ev_clr_w = bus.btn_clear      & ~btn_prev_q[2];

    // All event decisions use the pre-edge running value.
    assign clear_w    = ev_clr_w & ~running_q;
    assign tick_w     = running_q && (pre_q == C_PRE_LAST);
    assign ref_last_w = (ref_q == C_REF_LAST);

    // Ripple BCD increment: a 9 rolls to 0 and passes the carry upward in the
    // same edge. A carry out of the top digit is the wrap condition.
    always_comb begin
        logic carry;
        digits_inc_w = digits_q;
        carry        = tick_w;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (digits_q[4*i +: 4] == 4'd9) begin
                    digits_inc_w[4*i +: 4] = 4'd0;
                end else begin
                    digits_inc_w[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                    carry                  = 1'b0;
                end
            end
        end
        wrap_w = carry;
    end

    // ------------------------------------------------------------------------
    // Counter / control next state
    // ------------------------------------------------------------------------
    always_comb begin
        running_d    = running_q ^ ev_ss_w;
        lap_active_d = lap_active_q;
        snap_d       = snap_q;
        overflow_d   = overflow_q | wrap_w;
        digits_d     = digits_inc_w;
        pre_d        = pre_q;

        // The prescaler only advances while running, so a stop keeps the
        // partial tick for the next start.
        if (running_q) begin
            pre_d = tick_w ? '0 : pre_q + C_PRE_W'(1);
        end

        if (clear_w) begin
            // Clear only acts while stopped, so it never races a tick and
            // takes priority over a simultaneous lap press.
            digits_d     = '0;
            pre_d        = '0;
            lap_active_d = 1'b0;
            overflow_d   = 1'b0;
        end else if (ev_lap_w) begin
            if (lap_active_q) begin
                lap_active_d = 1'b0;
            end else if (running_q) begin
                snap_d       = digits_q;   // pre-edge count
                lap_active_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Display scan next state
    // ------------------------------------------------------------------------
    assign disp_w = lap_active_q ? snap_q : digits_q;

    always_comb begin
        disp_digit_w = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == C_IDX_W'(i)) begin
                disp_digit_w = disp_w[4*i +: 4];
            end
        end
    end

    always_comb begin
        ref_d = ref_last_w ? '0 : ref_q + C_REF_W'(1);
        idx_d = idx_q;
        seg_d = seg_q;
        an_d  = an_q;
        // an and seg load together so the lit digit always matches its code.
        if (ref_last_w) begin
            for (int i = 0; i < DIGITS; i++) begin
                an_d[i] = (idx_q != C_IDX_W'(i));
            end
            seg_d    = seg_code(disp_digit_w);
            seg_d[7] = ~(C_DP_EN && (idx_q == C_DP_IDX));
            idx_d    = (idx_q == C_IDX_LAST) ? '0 : idx_q + C_IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (rst) begin
            btn_prev_q   <= 3'b111;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            digits_q     <= '0;
            snap_q       <= '0;
            pre_q        <= '0;
            ref_q        <= '0;
            idx_q        <= '0;
            seg_q        <= 8'hFF;
            an_q         <= '1;
        end else begin
            btn_prev_q   <= {bus.btn_clear, bus.btn_lap, bus.btn_start_stop};
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
            digits_q     <= digits_d;
            snap_q       <= snap_d;
            pre_q        <= pre_d;
            ref_q        <= ref_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.running    = running_q;
    assign bus.lap_active = lap_active_q;
    assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_stopwatch_mux
// Description : Self-checking bench for bcd_stopwatch_mux. Two instances:
//               A (4 digits, fast tick/scan) and B (2 digits, no dp) so the
//               wrap case is reachable quickly. A cycle-level reference model
//               working on integer counts tracks both instances every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch_mux;

    localparam int A_DIG = 4, A_TD = 4, A_RD = 3, A_DP = 2;
    localparam int B_DIG = 2, B_TD = 2, B_RD = 2, B_DP = 2;

    logic mclk = 1'b0;
    logic rst;
    always #5 mclk = ~mclk;

    bcd_stopwatch_mux_if #(.DIGITS(A_DIG)) ifa ();
    bcd_stopwatch_mux_if #(.DIGITS(B_DIG)) ifb ();

    bcd_stopwatch_mux #(.DIGITS(A_DIG), .TICK_DIV(A_TD), .REFRESH_DIV(A_RD), .DP_POS(A_DP))
        u_dut_a (.mclk(mclk), .rst(rst), .bus(ifa));
    bcd_stopwatch_mux #(.DIGITS(B_DIG), .TICK_DIV(B_TD), .REFRESH_DIV(B_RD), .DP_POS(B_DP))
        u_dut_b (.mclk(mclk), .rst(rst), .bus(ifb));

    // ------------------------------------------------------------------------
    // Reference model: count kept as a plain integer, digits by division.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic       running;
        logic       lap;
        logic       ovf;
        logic [2:0] prev;
        int         count;
        int         snap;
        int         pre;
        int         refc;
        int         idx;
        logic [7:0] seg;
        logic [7:0] an;
    } m_t;

    m_t ma, mb;

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;  default: return 8'hFF;
        endcase
    endfunction

    function automatic m_t step(input m_t s, input logic r, input logic ss, input logic lp,
                                input logic cl, input int nd, input int td, input int rd,
                                input int dp);
        m_t   n;
        logic ess, elp, ecl, tick;
        int   disp;
        if (r) begin
            n.running = 1'b0; n.lap = 1'b0; n.ovf = 1'b0; n.prev = 3'b111;
            n.count = 0; n.snap = 0; n.pre = 0; n.refc = 0; n.idx = 0;
            n.seg = 8'hFF; n.an = 8'hFF;
            return n;
        end
        n    = s;
        ess  = ss && !s.prev[0];
        elp  = lp && !s.prev[1];
        ecl  = cl && !s.prev[2];
        n.prev = {cl, lp, ss};
        tick = s.running && (s.pre == td - 1);
        if (s.running) n.pre = tick ? 0 : s.pre + 1;
        if (tick) begin
            if (s.count == pow10(nd) - 1) begin
                n.count = 0;
                n.ovf   = 1'b1;
            end else begin
                n.count = s.count + 1;
            end
        end
        if (ess) n.running = !s.running;
        if (ecl && !s.running) begin
            n.count = 0; n.pre = 0; n.lap = 1'b0; n.ovf = 1'b0;
        end else if (elp) begin
            if (s.lap) n.lap = 1'b0;
            else if (s.running) begin
                n.lap  = 1'b1;
                n.snap = s.count;
            end
        end
        if (s.refc == rd - 1) begin
            n.refc = 0;
            disp   = s.lap ? s.snap : s.count;
            n.seg  = seg_of((disp / pow10(s.idx)) % 10);
            if (s.idx == dp) n.seg[7] = 1'b0;
            n.an   = ~(8'h01 << s.idx);
            n.idx  = (s.idx + 1) % nd;
        end else begin
            n.refc = s.refc + 1;
        end
        return n;
    endfunction

    always @(posedge mclk) begin
        ma = step(ma, rst, ifa.btn_start_stop, ifa.btn_lap, ifa.btn_clear, A_DIG, A_TD, A_RD, A_DP);
        mb = step(mb, rst, ifb.btn_start_stop, ifb.btn_lap, ifb.btn_clear, B_DIG, B_TD, B_RD, B_DP);
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int   checks = 0;
    int   errors = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Advance one clock and compare both instances with the model.
    task automatic cyc();
        @(negedge mclk);
        if (cmp_en) begin
            chk("A_vs_model",
                32'({ifa.seg, ifa.an, ifa.running, ifa.lap_active, ifa.overflow}),
                32'({ma.seg, ma.an[3:0], ma.running, ma.lap, ma.ovf}));
            chk("B_vs_model",
                32'({ifb.seg, ifb.an, ifb.running, ifb.lap_active, ifb.overflow}),
                32'({mb.seg, mb.an[1:0], mb.running, mb.lap, mb.ovf}));
        end
    endtask

    typedef struct packed {
        logic ss;
        logic lp;
        logic cl;
        logic er;   // expected running
        logic el;   // expected lap_active
    } vec_t;

    vec_t tbl [24];

    initial begin
        logic [3:0] an_e;
        logic [7:0] seg_e;
        int         sidx;
        logic       found;

        // {start_stop, lap, clear, running, lap_active} after the edge
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // lap while stopped: ignored
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};  // start
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};  // lap capture
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};  // clear while running: ignored
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // stop + lap release
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // lap while stopped: ignored
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // stop keeps lap
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};  // clear + lap stopped
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};  // clear + start stopped
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        ifa.btn_start_stop = 1'b0; ifa.btn_lap = 1'b0; ifa.btn_clear = 1'b0;
        ifb.btn_start_stop = 1'b1; ifb.btn_lap = 1'b0; ifb.btn_clear = 1'b0;
        repeat (3) @(negedge mclk);
        cmp_en = 1'b1;

        // Reset state
        chk("rst_seg",  32'(ifa.seg), 32'h0FF);
        chk("rst_an",   32'(ifa.an),  32'hF);
        chk("rst_run",  32'(ifa.running), 32'd0);
        chk("rst_lap",  32'(ifa.lap_active), 32'd0);
        chk("rst_ovf",  32'(ifa.overflow), 32'd0);

        // Blanking, then first scan loads every REFRESH_DIV edges
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            cyc();
            if (e < 3) begin
                an_e  = 4'hF;
                seg_e = 8'hFF;
            end else begin
                sidx  = (e - 3) / 3;
                an_e  = 4'hF & ~(4'h1 << sidx);
                seg_e = (sidx == 2) ? 8'h40 : 8'hC0;
            end
            chk($sformatf("scan_an_e%0d", e), 32'(ifa.an), 32'(an_e));
            chk($sformatf("scan_seg_e%0d", e), 32'(ifa.seg), 32'(seg_e));
            if (e == 1) chk("B_held_through_reset", 32'(ifb.running), 32'd0);
        end

        // Overflow on the 2-digit instance: tick k lands at start edge + 2k
        ifb.btn_start_stop = 1'b0;
        cyc();
        ifb.btn_start_stop = 1'b1;
        cyc();
        chk("B_start", 32'(ifb.running), 32'd1);
        ifb.btn_start_stop = 1'b0;
        repeat (198) cyc();
        cyc();
        chk("B_ovf_before_wrap", 32'(ifb.overflow), 32'd0);
        cyc();
        chk("B_ovf_after_wrap", 32'(ifb.overflow), 32'd1);
        chk("B_run_after_wrap", 32'(ifb.running), 32'd1);

        // Control-rule table on instance A
        for (int i = 0; i < 24; i++) begin
            ifa.btn_start_stop = tbl[i].ss;
            ifa.btn_lap        = tbl[i].lp;
            ifa.btn_clear      = tbl[i].cl;
            cyc();
            chk($sformatf("tbl%0d_run", i), 32'(ifa.running), 32'(tbl[i].er));
            chk($sformatf("tbl%0d_lap", i), 32'(ifa.lap_active), 32'(tbl[i].el));
        end

        // Clear, count 40 ticks, stop, then look at digit 1
        ifa.btn_clear = 1'b1;
        cyc();
        ifa.btn_clear = 1'b0;
        chk("A_clear_ovf", 32'(ifa.overflow), 32'd0);
        ifa.btn_start_stop = 1'b1;
        cyc();
        ifa.btn_start_stop = 1'b0;
        repeat (160) cyc();
        ifa.btn_start_stop = 1'b1;
        cyc();
        ifa.btn_start_stop = 1'b0;
        chk("A_stopped", 32'(ifa.running), 32'd0);
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            cyc();
            if (ifa.an == 4'hD) found = 1'b1;
        end
        chk("A_idx1_seen", 32'(found), 32'd1);
        if (found) chk("A_idx1_seg_0040", 32'(ifa.seg), 32'h99);

        // Reset in the middle of counting
        ifa.btn_start_stop = 1'b1;
        cyc();
        ifa.btn_start_stop = 1'b0;
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_seg", 32'(ifa.seg), 32'h0FF);
        chk("midrst_an",  32'(ifa.an),  32'hF);
        chk("midrst_run", 32'(ifa.running), 32'd0);
        chk("midrst_B_ovf", 32'(ifb.overflow), 32'd0);
        chk("midrst_B_run", 32'(ifb.running), 32'd0);
        rst = 1'b0;

        // Random buttons and occasional reset, tracked by the model
        for (int k = 0; k < 5000; k++) begin
            ifa.btn_start_stop = ($urandom_range(0, 15) == 0);
            ifa.btn_lap        = ($urandom_range(0, 5) == 0);
            ifa.btn_clear      = ($urandom_range(0, 7) == 0);
            ifb.btn_start_stop = ($urandom_range(0, 39) == 0);
            ifb.btn_lap        = ($urandom_range(0, 9) == 0);
            ifb.btn_clear      = ($urandom_range(0, 15) == 0);
            rst                = ($urandom_range(0, 1499) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
